mips_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit (MDU) for the next-generation MIPS datapath, parametrised in operand WIDTH.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, into architectural HI/LO registers. Supports MTHI/MTLO writes.
- Sits beside the ALU. The pipeline stalls while busy=1 and reads HI/LO directly for MFHI/MFLO.

---
 rtl/mips_muldiv_pkg.sv | 24 ++
 rtl/mips_muldiv_step.sv | 44 ++++
 rtl/mips_muldiv.sv | 178 +++++++++++++++++
 tb/tb_mips_muldiv.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit.
//   mdu_op_t    : operation codes presented on the op port
//   mdu_state_t : control FSM states
//   MDU_OP_W    : width of the op port
package mips_muldiv_pkg;

    localparam int MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mips_muldiv_step.sv
// Single iteration of the MDU datapath (purely combinational).
//   is_div_i : 1 = restoring shift-subtract step, 0 = shift-add step
//   hi_i     : upper accumulator half (partial product high / partial remainder)
//   lo_i     : lower accumulator half (multiplier bits / dividend-quotient bits)
//   opnd_i   : multiplicand (mul) or divisor (div)
//   hi_o     : next upper accumulator half
//   lo_o     : next lower accumulator half
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Multiply: add multiplicand when the current multiplier LSB is set, keeping
    // the carry so the right shift brings it into the product.
    assign sum = {1'b0, hi_i} + ({1'b0, opnd_i} & {(WIDTH+1){lo_i[0]}});

    // Divide: shift the next dividend bit into the remainder. When the divisor
    // fits, the true difference is below 2^WIDTH, so a WIDTH-bit subtract suffices.
    assign shifted = {hi_i, lo_i[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, opnd_i});
    assign diff    = shifted[WIDTH-1:0] - opnd_i;

    always_comb begin
        if (is_div_i) begin
            hi_o = fits ? diff : shifted[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], fits};
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT(U)/DIV(U) take WIDTH+1 busy cycles then pulse done; MTHI/MTLO write
// directly from IDLE. Signed MULT/DIV exist only when MIPS_MULDIV_SIGNED_EN
// is defined; otherwise they behave as MULTU/DIVU.
//   clk   : clock          reset : sync active-high reset
//   start : request        op    : operation code (mdu_op_t)
//   a, b  : operands       busy  : operation in flight
//   done  : result pulse   div0  : divide-by-zero flag (with done)
//   hi/lo : HI/LO registers
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                busy,
    output logic                done,
    output logic                div0,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d, araw_q, araw_d;
    logic             is_div_q, is_div_d;
`ifdef MIPS_MULDIV_SIGNED_EN
    logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
`endif

    logic [WIDTH-1:0]   step_hi, step_lo;
    logic               sgn;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .opnd_i   (opnd_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        araw_d   = araw_q;
        is_div_d = is_div_q;
`ifdef MIPS_MULDIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        sgn       = (op == OP_MULT) || (op == OP_DIV);
`else
        sgn       = 1'b0;
`endif
        a_abs = (sgn && a[WIDTH-1]) ? -a : a;
        b_abs = (sgn && b[WIDTH-1]) ? -b : b;
        prod  = {acc_hi_q, acc_lo_q};
        quo   = acc_lo_q;
        rem   = acc_hi_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (mdu_op_t'(op))
                        OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                            state_d  = S_RUN;
                            cnt_d    = CNT_W'(WIDTH);
                            is_div_d = op[1];
                            acc_hi_d = '0;
                            acc_lo_d = op[1] ? a_abs : b_abs;
                            opnd_d   = op[1] ? b_abs : a_abs;
                            araw_d   = a;
`ifdef MIPS_MULDIV_SIGNED_EN
                            neg_res_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = sgn & a[WIDTH-1];
`endif
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = S_FINISH;
            end
            S_FINISH: begin
`ifdef MIPS_MULDIV_SIGNED_EN
                // Most-negative / -1 needs no special case: the unsigned
                // quotient is 2^(WIDTH-1), both signs negative so no negate,
                // leaving lo = most-negative and hi = 0.
                if (neg_res_q) begin
                    prod = -prod;
                    quo  = -quo;
                end
                if (neg_rem_q)
                    rem = -rem;
`endif
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (opnd_q == '0) begin
                    hi_d   = araw_q;
                    lo_d   = '1;
                    div0_d = 1'b1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Working registers are always reloaded on start, so they need no reset.
    always_ff @(posedge clk) begin
        acc_hi_q <= acc_hi_d;
        acc_lo_q <= acc_lo_d;
        opnd_q   <= opnd_d;
        araw_q   <= araw_d;
        is_div_q <= is_div_d;
`ifdef MIPS_MULDIV_SIGNED_EN
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
`endif
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv at WIDTH=32. Inputs change at negedge or
// just after posedge; outputs are sampled at negedge.
module tb_mips_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mips_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Present a request for one rising edge; called at a negedge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count cycles after issue until done (bounded). busy_bad counts cycles
    // where busy differs from the expected window 1..W+1. At cycle inj a
    // MTLO of 0xDEAD is presented (0 = never).
    task automatic wait_done(input int inj, output int cyc, output int busy_bad);
        cyc = 0; busy_bad = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (busy !== (cyc <= W + 1)) busy_bad++;
            if (cyc == inj) begin
                start = 1'b1; op = 3'b101; a = 32'hDEAD;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1 || cyc >= 100) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (div0 !== 1'b0) begin n_fail++; $display("FAIL reset_div0 got %b want 0", div0); end
        if (hi !== '0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        if (lo !== '0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
        reset = 1'b0;
    endtask

    task automatic test_multu;
        int cyc, bb;
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, cyc, bb);
        n_checks += 5;
        if (cyc !== 34) begin n_fail++; $display("FAIL multu_latency got %0d want 34", cyc); end
        if (bb !== 0) begin n_fail++; $display("FAIL multu_busy_window got %0d bad cycles want 0", bb); end
        if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", lo); end
        if (div0 !== 1'b0) begin n_fail++; $display("FAIL multu_div0 got %b want 0", div0); end
        @(negedge clk);
        n_checks += 2;
        if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse got %b want 0", done); end
        if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi_hold got %h want fffffffe", hi); end
    endtask

    task automatic test_mult;
        int cyc, bb;
        logic [W-1:0] ehi;
`ifdef MIPS_MULDIV_SIGNED_EN
        ehi = 32'hFFFFFFFF;
`else
        ehi = 32'h00000006;
`endif
        issue(3'b001, 32'hFFFFFFFD, 32'd7);
        wait_done(0, cyc, bb);
        n_checks += 3;
        if (cyc !== 34) begin n_fail++; $display("FAIL mult_latency got %0d want 34", cyc); end
        if (hi !== ehi) begin n_fail++; $display("FAIL mult_hi got %h want %h", hi, ehi); end
        if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    endtask

    task automatic test_div;
        int cyc, bb;
        logic [W-1:0] eq1, er1, eq2, er2;
`ifdef MIPS_MULDIV_SIGNED_EN
        eq1 = 32'hFFFFFFFD; er1 = 32'hFFFFFFFF;
        eq2 = 32'h80000000; er2 = 32'h00000000;
`else
        eq1 = 32'h7FFFFFFC; er1 = 32'h00000001;
        eq2 = 32'h00000000; er2 = 32'h80000000;
`endif
        issue(3'b011, 32'hFFFFFFF9, 32'd2);
        wait_done(0, cyc, bb);
        n_checks += 3;
        if (lo !== eq1) begin n_fail++; $display("FAIL div_neg_lo got %h want %h", lo, eq1); end
        if (hi !== er1) begin n_fail++; $display("FAIL div_neg_hi got %h want %h", hi, er1); end
        if (div0 !== 1'b0) begin n_fail++; $display("FAIL div_neg_div0 got %b want 0", div0); end
        issue(3'b011, 32'h80000000, 32'hFFFFFFFF);
        wait_done(0, cyc, bb);
        n_checks += 3;
        if (lo !== eq2) begin n_fail++; $display("FAIL div_ovf_lo got %h want %h", lo, eq2); end
        if (hi !== er2) begin n_fail++; $display("FAIL div_ovf_hi got %h want %h", hi, er2); end
        if (div0 !== 1'b0) begin n_fail++; $display("FAIL div_ovf_div0 got %b want 0", div0); end
    endtask

    task automatic test_div0;
        int cyc, bb;
        issue(3'b010, 32'd100, 32'd0);
        wait_done(0, cyc, bb);
        n_checks += 5;
        if (cyc !== 34) begin n_fail++; $display("FAIL div0_latency got %0d want 34", cyc); end
        if (bb !== 0) begin n_fail++; $display("FAIL div0_busy_window got %0d bad cycles want 0", bb); end
        if (div0 !== 1'b1) begin n_fail++; $display("FAIL div0_flag got %b want 1", div0); end
        if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_lo got %h want ffffffff", lo); end
        if (hi !== 32'd100) begin n_fail++; $display("FAIL div0_hi got %h want 00000064", hi); end
        @(negedge clk);
        n_checks += 2;
        if (div0 !== 1'b0) begin n_fail++; $display("FAIL div0_clear got %b want 0", div0); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL div0_done_clear got %b want 0", done); end
    endtask

    task automatic test_mthi_mtlo;
        int dn;
        dn = 0;
        issue(3'b100, 32'h1234, 32'h0);
        @(negedge clk);
        n_checks += 3;
        if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_hi got %h want 00001234", hi); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %b want 0", busy); end
        if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mthi_lo_hold got %h want ffffffff", lo); end
        issue(3'b101, 32'h5678, 32'h0);
        if (done !== 1'b0) dn++;
        @(negedge clk);
        if (done !== 1'b0) dn++;
        n_checks += 3;
        if (lo !== 32'h5678) begin n_fail++; $display("FAIL mtlo_lo got %h want 00005678", lo); end
        if (hi !== 32'h1234) begin n_fail++; $display("FAIL mtlo_hi_hold got %h want 00001234", hi); end
        if (dn !== 0) begin n_fail++; $display("FAIL mtxx_done got %0d pulses want 0", dn); end
    endtask

    task automatic test_busy_ignore;
        int cyc, bb;
        issue(3'b000, 32'd6, 32'd7);
        wait_done(3, cyc, bb);
        n_checks += 4;
        if (cyc !== 34) begin n_fail++; $display("FAIL ignore_latency got %0d want 34", cyc); end
        if (bb !== 0) begin n_fail++; $display("FAIL ignore_busy_window got %0d bad cycles want 0", bb); end
        if (lo !== 32'd42) begin n_fail++; $display("FAIL ignore_lo got %h want 0000002a", lo); end
        if (hi !== 32'd0) begin n_fail++; $display("FAIL ignore_hi got %h want 0", hi); end
    endtask

    task automatic test_back_to_back;
        int cyc, bb;
        issue(3'b000, 32'd3, 32'd3);
        wait_done(0, cyc, bb);
        issue(3'b010, 32'd100, 32'd7);
        wait_done(0, cyc, bb);
        n_checks += 4;
        if (cyc !== 34) begin n_fail++; $display("FAIL b2b_latency got %0d want 34", cyc); end
        if (bb !== 0) begin n_fail++; $display("FAIL b2b_busy_window got %0d bad cycles want 0", bb); end
        if (lo !== 32'd14) begin n_fail++; $display("FAIL b2b_lo got %h want 0000000e", lo); end
        if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_hi got %h want 00000002", hi); end
    endtask

    task automatic test_reserved;
        issue(3'b110, 32'hAAAA, 32'h5555);
        @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reserved_busy got %b want 0", busy); end
        if (lo !== 32'd14) begin n_fail++; $display("FAIL reserved_lo got %h want 0000000e", lo); end
        if (hi !== 32'd2) begin n_fail++; $display("FAIL reserved_hi got %h want 00000002", hi); end
    endtask

    task automatic test_reset_mid;
        int cyc, bb;
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", done); end
        if (hi !== '0) begin n_fail++; $display("FAIL rstmid_hi got %h want 0", hi); end
        if (lo !== '0) begin n_fail++; $display("FAIL rstmid_lo got %h want 0", lo); end
        issue(3'b000, 32'd3, 32'd5);
        wait_done(0, cyc, bb);
        n_checks += 4;
        if (cyc !== 34) begin n_fail++; $display("FAIL rstmid_latency got %0d want 34", cyc); end
        if (bb !== 0) begin n_fail++; $display("FAIL rstmid_busy_window got %0d bad cycles want 0", bb); end
        if (lo !== 32'd15) begin n_fail++; $display("FAIL rstmid_lo_after got %h want 0000000f", lo); end
        if (hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_hi_after got %h want 0", hi); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div0();
        test_mthi_mtlo();
        test_busy_ignore();
        test_back_to_back();
        test_reserved();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
